mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 1023; wait-state cycles before a transaction is aborted; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 m_req  input  4  per-master level request; master i held high until m_done[i].
REQ-005 m_we  input  4  per-master type, 1=write, 0=read.
REQ-006 m_w / m_hw  input  4 each  per-master word / halfword size flags; both low = byte.
REQ-007 m_adr  input  128  master i address at bits [32i+31:32i].
REQ-008 m_wdata  input  128  master i write data at bits [32i+31:32i].
REQ-009 m_done  output  4  one-cycle completion pulse to the granted master.
REQ-010 m_err  output  1  high with m_done when the transaction timed out.
REQ-011 m_rdata  output  32  registered read data, valid with m_done of a read.
REQ-012 grant  output  4  one-hot current owner; 0 when idle.
REQ-013 read_req / write_req  output  1 each  one-cycle request pulse to the memory controller.
REQ-014 read_w, read_hw, write_w, write_hw  output  1 each  size of the issued access.
REQ-015 read_adr, write_adr, write_data  output  32 each  latched attributes of the issued access.
REQ-016 read_valid  input  1  memory read-completion pulse; read_data valid in the same cycle.
REQ-017 read_data  input  32  memory read data.
REQ-018 write_finish  input  1  memory write-completion pulse.

Function
REQ-019 FSM states IDLE, ISSUE and WAIT; exactly one transaction is outstanding at a time.
REQ-020 IDLE: if any m_req is high, grant the first requesting master at or after rr_ptr (modulo 4), latch its we/w/hw/adr/wdata, set grant, and go to ISSUE.
REQ-021 Round-robin: on grant of master g, set rr_ptr to (g+1) mod 4; rr_ptr reset value is 0.
REQ-022 ISSUE: pulse write_req (latched we=1) or read_req (we=0) for exactly one cycle with the latched attributes, clear the wait counter, and go to WAIT.
REQ-023 Address, size and data outputs hold their latched values from ISSUE through the end of WAIT.
REQ-024 WAIT, read: on read_valid, capture read_data into m_rdata; next cycle pulse m_done[g], clear grant, and go to IDLE.
REQ-025 WAIT, write: on write_finish, next cycle pulse m_done[g], clear grant, and go to IDLE.
REQ-026 Completion of the wrong type is ignored (read_valid during a write, write_finish during a read).
REQ-027 Timeout: the 16-bit wait counter increments each WAIT cycle; on reaching TIMEOUT (nonzero) with no completion, pulse m_done[g] with m_err=1 and m_rdata=32'hdeadbeef, then go to IDLE.
REQ-028 If completion and timeout coincide, completion wins and m_err stays 0.
REQ-029 Arbitration latency: request seen in IDLE -> req pulse 1 cycle later; completion -> m_done 1 cycle later; the granted master's req must drop the cycle after m_done.
REQ-030 Deasserting m_req while granted does not abort the transaction; m_done is still pulsed.
REQ-031 After m_done the FSM re-arbitrates no earlier than the following cycle (IDLE takes one cycle).
REQ-032 m_done is one-hot or zero; m_err is 0 whenever m_done is 0.

Reset
REQ-033 On rst_n low, at any state including mid-transaction: FSM=IDLE, rr_ptr=0, grant=0, m_done=0, m_err=0, m_rdata=0, read_req=write_req=0, and all latched attributes 0.
REQ-034 An outstanding memory access at reset is abandoned; a read_valid/write_finish arriving after reset release is ignored in IDLE.

Verification
REQ-035 Single read: m_req=4'b0100, m_adr[2]=0x100 -> read_req pulse with read_adr=0x100; read_valid with read_data=0x12345678 -> next cycle m_done=4'b0100 and m_rdata=0x12345678.
REQ-036 Round-robin: all m_req=4'b1111 held, each completed -> grant order 0,1,2,3,0 from reset.
REQ-037 Write: master 1 we=1, w=1, adr=0x2000, wdata=0xcafef00d -> write_req pulse with those values; write_finish -> m_done=4'b0010 one cycle later.
REQ-038 Timeout: TIMEOUT=8, read with no read_valid -> m_done with m_err=1 and m_rdata=0xdeadbeef exactly 8 WAIT cycles after ISSUE.
REQ-039 Reset in WAIT: assert rst_n low mid-read -> all outputs 0 immediately; a later read_valid produces no m_done.
REQ-040 Wrong-type completion: write outstanding, read_valid pulses -> no m_done until write_finish.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Four-master round-robin arbiter in front of a single-outstanding memory controller.
// One transaction at a time: IDLE picks a master, ISSUE pulses the request, WAIT collects completion or times out.
module mem_bus_arbiter #(
   parameter int TIMEOUT = 1023
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [3:0]   m_req,
   input  logic [3:0]   m_we,
   input  logic [3:0]   m_w,
   input  logic [3:0]   m_hw,
   input  logic [127:0] m_adr,
   input  logic [127:0] m_wdata,
   output logic [3:0]   m_done,
   output logic         m_err,
   output logic [31:0]  m_rdata,
   output logic [3:0]   grant,
   output logic         read_req,
   output logic         write_req,
   output logic         read_w,
   output logic         read_hw,
   output logic         write_w,
   output logic         write_hw,
   output logic [31:0]  read_adr,
   output logic [31:0]  write_adr,
   output logic [31:0]  write_data,
   input  logic         read_valid,
   input  logic [31:0]  read_data,
   input  logic         write_finish
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
   localparam logic        TIMEOUT_EN  = (TIMEOUT != 0);
   localparam logic [31:0] ERR_DATA    = 32'hdeadbeef;

   state_t      state, state_nx;
   logic [1:0]  rr_ptr, rr_ptr_nx;
   logic [15:0] wait_cnt, wait_cnt_nx;
   logic [3:0]  grant_nx;
   logic [3:0]  done_nx;
   logic        err_nx;
   logic [31:0] rdata_nx;

   // Attributes of the transaction in flight, captured at grant time.
   logic        we_q, we_nx;
   logic        w_q, w_nx;
   logic        hw_q, hw_nx;
   logic [31:0] adr_q, adr_nx;
   logic [31:0] wdata_q, wdata_nx;

   logic        pick_valid;
   logic [1:0]  pick_idx;
   logic        completed;
   logic        timed_out;

   // Round-robin search: lowest offset from rr_ptr wins, so scan offsets high to low.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (m_req[rr_ptr + 2'(k)]) begin
            pick_valid = 1'b1;
            pick_idx   = rr_ptr + 2'(k);
         end
      end
   end

   assign completed = we_q ? write_finish : read_valid;
   assign timed_out = TIMEOUT_EN && ((wait_cnt + 16'd1) == TIMEOUT_CNT);

   // NOTE: every variable of this block gets its hold/default value first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nx    = state;
      rr_ptr_nx   = rr_ptr;
      wait_cnt_nx = wait_cnt;
      grant_nx    = grant;
      done_nx     = 4'b0000;
      err_nx      = 1'b0;
      rdata_nx    = m_rdata;
      we_nx       = we_q;
      w_nx        = w_q;
      hw_nx       = hw_q;
      adr_nx      = adr_q;
      wdata_nx    = wdata_q;

      unique case (state)
         IDLE: begin
            // The cycle carrying m_done is spent in IDLE without arbitrating,
            // because the finishing master may still hold its request.
            if (pick_valid && (m_done == 4'b0000)) begin
               grant_nx  = 4'b0001 << pick_idx;
               rr_ptr_nx = pick_idx + 2'd1;
               we_nx     = m_we[pick_idx];
               w_nx      = m_w[pick_idx];
               hw_nx     = m_hw[pick_idx];
               adr_nx    = m_adr[{pick_idx, 5'b00000} +: 32];
               wdata_nx  = m_wdata[{pick_idx, 5'b00000} +: 32];
               state_nx  = ISSUE;
            end
         end

         ISSUE: begin
            wait_cnt_nx = 16'd0;
            state_nx    = WAIT;
         end

         WAIT: begin
            if (completed) begin
               done_nx  = grant;
               grant_nx = 4'b0000;
               state_nx = IDLE;
               if (!we_q) begin
                  rdata_nx = read_data;
               end
            end else if (timed_out) begin
               done_nx  = grant;
               err_nx   = 1'b1;
               rdata_nx = ERR_DATA;
               grant_nx = 4'b0000;
               state_nx = IDLE;
            end else begin
               wait_cnt_nx = wait_cnt + 16'd1;
            end
         end

         default: begin
            grant_nx = 4'b0000;
            state_nx = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr_ptr   <= 2'd0;
         wait_cnt <= 16'd0;
         grant    <= 4'b0000;
         m_done   <= 4'b0000;
         m_err    <= 1'b0;
         m_rdata  <= 32'd0;
         we_q     <= 1'b0;
         w_q      <= 1'b0;
         hw_q     <= 1'b0;
         adr_q    <= 32'd0;
         wdata_q  <= 32'd0;
      end else begin
         state    <= state_nx;
         rr_ptr   <= rr_ptr_nx;
         wait_cnt <= wait_cnt_nx;
         grant    <= grant_nx;
         m_done   <= done_nx;
         m_err    <= err_nx;
         m_rdata  <= rdata_nx;
         we_q     <= we_nx;
         w_q      <= w_nx;
         hw_q     <= hw_nx;
         adr_q    <= adr_nx;
         wdata_q  <= wdata_nx;
      end
   end

   // Request strobes are decoded from the ISSUE state so they last exactly one cycle.
   assign read_req   = (state == ISSUE) && !we_q;
   assign write_req  = (state == ISSUE) && we_q;
   assign read_w     = w_q;
   assign read_hw    = hw_q;
   assign write_w    = w_q;
   assign write_hw   = hw_q;
   assign read_adr   = adr_q;
   assign write_adr  = adr_q;
   assign write_data = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: scenario tasks with a completion scoreboard.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_bus_arbiter;

   localparam int TO = 8;

   logic         clk;
   logic         rst_n;
   logic [3:0]   m_req, m_we, m_w, m_hw;
   logic [127:0] m_adr, m_wdata;
   logic [3:0]   m_done;
   logic         m_err;
   logic [31:0]  m_rdata;
   logic [3:0]   grant;
   logic         read_req, write_req;
   logic         read_w, read_hw, write_w, write_hw;
   logic [31:0]  read_adr, write_adr, write_data;
   logic         read_valid;
   logic [31:0]  read_data;
   logic         write_finish;

   typedef struct {
      logic [3:0]  done;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   mem_bus_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .m_req(m_req), .m_we(m_we), .m_w(m_w), .m_hw(m_hw),
      .m_adr(m_adr), .m_wdata(m_wdata),
      .m_done(m_done), .m_err(m_err), .m_rdata(m_rdata), .grant(grant),
      .read_req(read_req), .write_req(write_req),
      .read_w(read_w), .read_hw(read_hw), .write_w(write_w), .write_hw(write_hw),
      .read_adr(read_adr), .write_adr(write_adr), .write_data(write_data),
      .read_valid(read_valid), .read_data(read_data), .write_finish(write_finish)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_inputs();
      m_req = '0; m_we = '0; m_w = '0; m_hw = '0;
      m_adr = '0; m_wdata = '0;
      read_valid = 1'b0; read_data = '0; write_finish = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(1);
   endtask

   // Advances until a request strobe is visible; cyc counts the steps taken.
   task automatic wait_req(output int cyc, output bit ok);
      cyc = 0;
      ok  = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (read_req || write_req) begin
            ok = 1'b1;
            break;
         end
         step();
         cyc++;
      end
   endtask

   task automatic wait_done(output int cyc, output bit ok);
      cyc = 0;
      ok  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (m_done != 4'b0000) begin
            ok = 1'b1;
            break;
         end
         step();
         cyc++;
      end
   endtask

   task automatic pop_exp(output exp_t e, output bit ok);
      ok = (exp_q.size() != 0);
      e  = '{done: 4'b0000, err: 1'b0, rdata: 32'd0};
      if (ok) e = exp_q.pop_front();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      step(2);
      tests++;
      if (grant !== 4'b0000 || m_done !== 4'b0000 || m_err !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctrl: grant=%b m_done=%b m_err=%b, required 0000 0000 0", grant, m_done, m_err);
      end
      tests++;
      if (m_rdata !== 32'd0 || read_req !== 1'b0 || write_req !== 1'b0) begin
         fails++;
         $display("FAIL reset_strobe: m_rdata=%h read_req=%b write_req=%b, required 0", m_rdata, read_req, write_req);
      end
      tests++;
      if (read_adr !== 32'd0 || write_data !== 32'd0 || read_w !== 1'b0 || write_hw !== 1'b0) begin
         fails++;
         $display("FAIL reset_attr: read_adr=%h write_data=%h, required 0", read_adr, write_data);
      end
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic test_single_read();
      int cyc; bit ok; exp_t e;
      m_adr[64 +: 32] = 32'h0000_0100;
      m_w[2]  = 1'b1;
      m_we[2] = 1'b0;
      m_req   = 4'b0100;
      exp_q.push_back('{done: 4'b0100, err: 1'b0, rdata: 32'h1234_5678});
      step();
      tests++;
      if (read_req !== 1'b1 || write_req !== 1'b0 || read_adr !== 32'h100 || read_w !== 1'b1 || grant !== 4'b0100) begin
         fails++;
         $display("FAIL read_issue: read_req=%b write_req=%b read_adr=%h read_w=%b grant=%b, required 1 0 00000100 1 0100",
                  read_req, write_req, read_adr, read_w, grant);
      end
      step();
      tests++;
      if (read_req !== 1'b0) begin
         fails++;
         $display("FAIL read_req_pulse: read_req=%b in WAIT, required 0", read_req);
      end
      read_valid = 1'b1;
      read_data  = 32'h1234_5678;
      step();
      read_valid = 1'b0;
      read_data  = 32'h0;
      pop_exp(e, ok);
      tests++;
      if (!ok || m_done !== e.done || m_err !== e.err || m_rdata !== e.rdata) begin
         fails++;
         $display("FAIL read_done: m_done=%b m_err=%b m_rdata=%h, required %b %b %h", m_done, m_err, m_rdata, e.done, e.err, e.rdata);
      end
      m_req = 4'b0000;
      step();
      tests++;
      if (m_done !== 4'b0000 || grant !== 4'b0000) begin
         fails++;
         $display("FAIL read_done_pulse: m_done=%b grant=%b after pulse, required 0000 0000", m_done, grant);
      end
      step(2);
   endtask

   task automatic test_round_robin();
      int cyc; bit ok; exp_t e;
      logic [3:0] gq[$];
      logic [3:0] g;
      logic [31:0] adr_exp;
      do_reset();
      clear_inputs();
      for (int i = 0; i < 4; i++) m_adr[32*i +: 32] = 32'h1000 * (i + 1);
      for (int k = 0; k < 5; k++) gq.push_back(4'b0001 << (k % 4));
      m_req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_req(cyc, ok);
         g = gq.pop_front();
         adr_exp = 32'h1000 * ((k % 4) + 1);
         tests++;
         if (!ok || grant !== g || read_adr !== adr_exp) begin
            fails++;
            $display("FAIL rr_grant_%0d: ok=%b grant=%b read_adr=%h, required 1 %b %h", k, ok, grant, read_adr, g, adr_exp);
            break;
         end
         exp_q.push_back('{done: g, err: 1'b0, rdata: 32'ha0 + 32'(k)});
         step();
         read_valid = 1'b1;
         read_data  = 32'ha0 + 32'(k);
         step();
         read_valid = 1'b0;
         pop_exp(e, ok);
         tests++;
         if (!ok || m_done !== e.done || m_err !== e.err || m_rdata !== e.rdata) begin
            fails++;
            $display("FAIL rr_done_%0d: m_done=%b m_err=%b m_rdata=%h, required %b %b %h", k, m_done, m_err, m_rdata, e.done, e.err, e.rdata);
         end
      end
      m_req = 4'b0000;
      exp_q.delete();
      step(3);
   endtask

   task automatic test_write();
      int cyc; bit ok; exp_t e;
      bit early;
      clear_inputs();
      m_we[1] = 1'b1;
      m_w[1]  = 1'b1;
      m_hw[1] = 1'b0;
      m_adr[32 +: 32]   = 32'h0000_2000;
      m_wdata[32 +: 32] = 32'hcafe_f00d;
      m_req = 4'b0010;
      exp_q.push_back('{done: 4'b0010, err: 1'b0, rdata: m_rdata});
      wait_req(cyc, ok);
      tests++;
      if (!ok || write_req !== 1'b1 || read_req !== 1'b0 || write_adr !== 32'h2000 ||
          write_data !== 32'hcafef00d || write_w !== 1'b1 || write_hw !== 1'b0) begin
         fails++;
         $display("FAIL write_issue: write_req=%b read_req=%b adr=%h data=%h w=%b hw=%b, required 1 0 00002000 cafef00d 1 0",
                  write_req, read_req, write_adr, write_data, write_w, write_hw);
      end
      step();
      read_valid = 1'b1;
      read_data  = 32'h5555_5555;
      step();
      read_valid = 1'b0;
      early = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (m_done !== 4'b0000 || write_adr !== 32'h2000 || write_data !== 32'hcafef00d) early = 1'b1;
         if (i < 2) step();
      end
      tests++;
      if (early) begin
         fails++;
         $display("FAIL write_wrong_type: m_done=%b write_adr=%h during WAIT, required 0000 00002000", m_done, write_adr);
      end
      write_finish = 1'b1;
      step();
      write_finish = 1'b0;
      pop_exp(e, ok);
      tests++;
      if (!ok || m_done !== e.done || m_err !== e.err) begin
         fails++;
         $display("FAIL write_done: m_done=%b m_err=%b, required %b %b", m_done, m_err, e.done, e.err);
      end
      m_req = 4'b0000;
      step(2);
   endtask

   task automatic test_timeout();
      int cyc; bit ok; exp_t e;
      clear_inputs();
      m_adr[96 +: 32] = 32'h0000_3000;
      m_req = 4'b1000;
      exp_q.push_back('{done: 4'b1000, err: 1'b1, rdata: 32'hdeadbeef});
      wait_req(cyc, ok);
      wait_done(cyc, ok);
      pop_exp(e, ok);
      tests++;
      if (cyc !== TO + 1) begin
         fails++;
         $display("FAIL timeout_latency: m_done %0d cycles after ISSUE, required %0d", cyc, TO + 1);
      end
      tests++;
      if (!ok || m_done !== e.done || m_err !== e.err || m_rdata !== e.rdata) begin
         fails++;
         $display("FAIL timeout_done: m_done=%b m_err=%b m_rdata=%h, required %b %b %h", m_done, m_err, m_rdata, e.done, e.err, e.rdata);
      end
      m_req = 4'b0000;
      step();
      tests++;
      if (m_err !== 1'b0 || m_done !== 4'b0000) begin
         fails++;
         $display("FAIL timeout_err_clear: m_err=%b m_done=%b, required 0 0000", m_err, m_done);
      end
      step(2);
   endtask

   task automatic test_coincide();
      int cyc; bit ok; exp_t e;
      clear_inputs();
      m_req = 4'b1000;
      exp_q.push_back('{done: 4'b1000, err: 1'b0, rdata: 32'h0bad_cafe});
      wait_req(cyc, ok);
      step(TO);
      read_valid = 1'b1;
      read_data  = 32'h0bad_cafe;
      step();
      read_valid = 1'b0;
      pop_exp(e, ok);
      tests++;
      if (!ok || m_done !== e.done || m_err !== e.err || m_rdata !== e.rdata) begin
         fails++;
         $display("FAIL coincide_done: m_done=%b m_err=%b m_rdata=%h, required %b %b %h", m_done, m_err, m_rdata, e.done, e.err, e.rdata);
      end
      m_req = 4'b0000;
      step(2);
   endtask

   task automatic test_back_to_back();
      int cyc; bit ok; exp_t e;
      do_reset();
      clear_inputs();
      m_we[3] = 1'b1;
      m_wdata[96 +: 32] = 32'h7777_0003;
      m_req = 4'b1001;
      wait_req(cyc, ok);
      step();
      read_valid = 1'b1;
      read_data  = 32'h1;
      step();
      read_valid = 1'b0;
      m_req = 4'b1000;
      wait_req(cyc, ok);
      tests++;
      if (!ok || cyc != 2 || grant !== 4'b1000 || write_req !== 1'b1 || write_data !== 32'h77770003) begin
         fails++;
         $display("FAIL b2b_rearb: ok=%b gap=%0d grant=%b write_req=%b data=%h, required 1 2 1000 1 77770003",
                  ok, cyc, grant, write_req, write_data);
      end
      exp_q.push_back('{done: 4'b1000, err: 1'b0, rdata: 32'h1});
      step();
      write_finish = 1'b1;
      step();
      write_finish = 1'b0;
      pop_exp(e, ok);
      tests++;
      if (!ok || m_done !== e.done || m_err !== e.err || m_rdata !== e.rdata) begin
         fails++;
         $display("FAIL b2b_done: m_done=%b m_err=%b m_rdata=%h, required %b %b %h", m_done, m_err, m_rdata, e.done, e.err, e.rdata);
      end
      m_req = 4'b0000;
      step(2);
   endtask

   task automatic test_reset_mid();
      int cyc; bit ok;
      bit stray;
      clear_inputs();
      m_adr[0 +: 32] = 32'h0000_4444;
      m_req = 4'b0001;
      wait_req(cyc, ok);
      step(2);
      rst_n = 1'b0;
      #1;
      tests++;
      if (grant !== 4'b0000 || read_adr !== 32'd0 || read_req !== 1'b0 || m_done !== 4'b0000 || m_rdata !== 32'd0) begin
         fails++;
         $display("FAIL reset_mid_outputs: grant=%b read_adr=%h read_req=%b m_done=%b m_rdata=%h, required 0",
                  grant, read_adr, read_req, m_done, m_rdata);
      end
      m_req = 4'b0000;
      step();
      rst_n = 1'b1;
      step();
      read_valid = 1'b1;
      read_data  = 32'h9999_9999;
      step();
      read_valid = 1'b0;
      stray = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (m_done !== 4'b0000 || grant !== 4'b0000 || m_rdata !== 32'd0) stray = 1'b1;
         step();
      end
      tests++;
      if (stray) begin
         fails++;
         $display("FAIL reset_mid_stray: m_done=%b grant=%b m_rdata=%h after late read_valid, required 0", m_done, grant, m_rdata);
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_write();
      test_timeout();
      test_coincide();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
